// File: rtl/oam_dma_ctrl_pkg.sv
// Shared definitions for the FF46 OAM DMA sequencer: state encoding,
// register/OAM addresses and the echo-RAM source mapping.
package oam_dma_ctrl_pkg;

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_ARB   = 3'd1,
    DMA_READ  = 3'd2,
    DMA_WAIT  = 3'd3,
    DMA_WRITE = 3'd4,
    DMA_DONE  = 3'd5
  } dma_state_e;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;

  // Pages E0..FF alias work RAM at C0..DF.
  function automatic logic [7:0] map_src_hi(input logic [7:0] raw);
    if (raw >= 8'hE0) return raw - 8'h20;
    return raw;
  endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: copies LENGTH bytes from {src_hi,8'h00} into OAM,
// one read/write pair per byte over the shared MMU bus.
module oam_dma_ctrl
  import oam_dma_ctrl_pkg::*;
#(
  parameter int unsigned LENGTH       = 160,
  parameter logic [15:0] DST_BASE     = OAM_BASE,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iDmaWe,
  input  logic [7:0]  iDmaData,
  input  logic        iBusGrant,
  input  logic [7:0]  iMcuReadData,
  output logic        oBusRequest,
  output logic [15:0] oMcuAddr,
  output logic        oMcuReadRequest,
  output logic        oMcuWe,
  output logic [7:0]  oMcuData,
  output logic        oBusy,
  output logic        oDone,
  output logic [7:0]  oDmaReg
);

  localparam logic [7:0] LAST_INDEX = 8'(LENGTH - 1);
  localparam logic [2:0] LAST_WAIT  = 3'(READ_LATENCY - 1);

  dma_state_e state_q, state_d;
  logic [7:0] index_q, index_d;
  logic [7:0] src_q,   src_d;
  logic [7:0] data_q,  data_d;
  logic [7:0] reg_q,   reg_d;
  logic [2:0] lat_q,   lat_d;

  always_comb begin
    state_d         = state_q;
    index_d         = index_q;
    src_d           = src_q;
    data_d          = data_q;
    reg_d           = reg_q;
    lat_d           = lat_q;
    oBusRequest     = 1'b0;
    oBusy           = 1'b0;
    oMcuAddr        = '0;
    oMcuReadRequest = 1'b0;
    oMcuWe          = 1'b0;
    oMcuData        = '0;
    oDone           = 1'b0;

    case (state_q)
      DMA_IDLE: ;
      DMA_ARB: begin
        oBusRequest = 1'b1;
        oBusy       = 1'b1;
        if (iBusGrant) state_d = DMA_READ;
      end
      DMA_READ: begin
        oBusRequest     = 1'b1;
        oBusy           = 1'b1;
        oMcuAddr        = {src_q, index_q};
        oMcuReadRequest = 1'b1;
        lat_d           = '0;
        state_d         = DMA_WAIT;
      end
      DMA_WAIT: begin
        oBusRequest = 1'b1;
        oBusy       = 1'b1;
        oMcuAddr    = {src_q, index_q};
        if (lat_q == LAST_WAIT) begin
          data_d  = iMcuReadData;
          state_d = DMA_WRITE;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      DMA_WRITE: begin
        oBusRequest = 1'b1;
        oBusy       = 1'b1;
        oMcuAddr    = DST_BASE + {8'h00, index_q};
        oMcuData    = data_q;
        oMcuWe      = 1'b1;
        if (index_q == LAST_INDEX) begin
          state_d = DMA_DONE;
        end else begin
          index_d = index_q + 8'd1;
          state_d = iBusGrant ? DMA_READ : DMA_ARB;
        end
      end
      DMA_DONE: begin
        oDone   = 1'b1;
        state_d = DMA_IDLE;
      end
      default: state_d = DMA_IDLE;
    endcase

    // A FF46 write restarts from any state; an in-flight byte is dropped,
    // including suppressing a write strobe that would fire this cycle.
    if (iDmaWe) begin
      src_d   = map_src_hi(iDmaData);
      reg_d   = iDmaData;
      index_d = '0;
      lat_d   = '0;
      state_d = DMA_ARB;
      oMcuWe  = 1'b0;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= DMA_IDLE;
      index_q <= '0;
      src_q   <= '0;
      data_q  <= '0;
      reg_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      src_q   <= src_d;
      data_q  <= data_d;
      reg_q   <= reg_d;
      lat_q   <= lat_d;
    end
  end

  assign oDmaReg = reg_q;

endmodule
